// File: rtl/dmem_responder_if.sv
// Load/store port between the MEM stage (master) and the data-memory responder (slave).
interface dmem_responder_if;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        busy;
  logic        ack;
  logic [31:0] rdata;
  logic        err;

  modport master (
    output req, we, addr, wdata,
    input  busy, ack, rdata, err
  );

  modport slave (
    input  req, we, addr, wdata,
    output busy, ack, rdata, err
  );
endinterface

// File: rtl/dmem_responder.sv
// Data-memory responder: one word read/write per request, answered LATENCY cycles after
// acceptance, with a combinational busy so the CPU can stall its pipeline.
module dmem_responder #(
  parameter int unsigned DEPTH   = 32,
  parameter int unsigned LATENCY = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  dmem_responder_if.slave  bus
);

  localparam int unsigned IdxW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = (LATENCY > 2) ? $clog2(LATENCY - 1) : 1;
  localparam logic [CntW-1:0] CntInit = CntW'((LATENCY > 1) ? (LATENCY - 2) : 0);

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              we_q, we_d;
  logic [31:0]       addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              ack_q, ack_d;
  logic              err_q, err_d;

  logic [31:0]       mem_q [DEPTH];

  logic              cur_we;
  logic [31:0]       cur_addr;
  logic [31:0]       cur_wdata;
  logic              cur_err;
  logic [IdxW-1:0]   cur_idx;
  logic              enter_resp;

  // In IDLE the live request is used so LATENCY==1 can complete on the accepting edge.
  always_comb begin
    if (state_q == StIdle) begin
      cur_we    = bus.we;
      cur_addr  = bus.addr;
      cur_wdata = bus.wdata;
    end else begin
      cur_we    = we_q;
      cur_addr  = addr_q;
      cur_wdata = wdata_q;
    end
    cur_err = (|cur_addr[1:0]) | (|cur_addr[31:IdxW+2]);
    cur_idx = cur_addr[IdxW+1:2];
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    ack_d      = 1'b0;
    err_d      = 1'b0;
    enter_resp = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (bus.req) begin
          we_d    = bus.we;
          addr_d  = bus.addr;
          wdata_d = bus.wdata;
          if (LATENCY == 1) begin
            enter_resp = 1'b1;
          end else begin
            state_d = StWait;
            cnt_d   = CntInit;
          end
        end
      end
      StWait: begin
        if (cnt_q == '0) begin
          enter_resp = 1'b1;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase

    if (enter_resp) begin
      state_d = StResp;
      ack_d   = 1'b1;
      err_d   = cur_err;
      if (!cur_we) begin
        rdata_d = cur_err ? 32'h0 : mem_q[cur_idx];
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
    end
  end

  // Storage is deliberately outside reset so its contents survive it.
  always_ff @(posedge clk_i) begin
    if (enter_resp && cur_we && !cur_err && !rst_i) begin
      mem_q[cur_idx] <= cur_wdata;
    end
  end

  assign bus.busy  = ((state_q == StIdle) && bus.req) || (state_q == StWait);
  assign bus.ack   = ack_q;
  assign bus.err   = err_q;
  assign bus.rdata = rdata_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: LATENCY=4 and LATENCY=1 instances sharing clock and reset.
module tb_dmem_responder;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  dmem_responder_if bus ();
  dmem_responder_if bus1 ();

  dmem_responder #(.DEPTH(32), .LATENCY(4)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus.slave)
  );

  dmem_responder #(.DEPTH(32), .LATENCY(1)) dut1 (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus1.slave)
  );

  logic [15:0] r_busy;
  int          r_lat;
  logic        r_err;
  logic [31:0] r_rdata;
  int          r_cyc;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One transaction on the LATENCY=4 instance; tog scrambles req/fields after acceptance.
  task automatic xact(input logic w, input logic [31:0] a, input logic [31:0] d, input bit tog);
    int c;
    bit seen;
    bus.req = 1'b1; bus.we = w; bus.addr = a; bus.wdata = d;
    c = 0; seen = 0; r_busy = '0; r_lat = 99; r_err = 1'bx; r_rdata = 'x;
    while (!seen && c < 20) begin
      @(negedge clk);
      if (c < 16) r_busy[c] = bus.busy;
      if (bus.ack) begin
        seen = 1; r_lat = c; r_err = bus.err; r_rdata = bus.rdata; r_cyc = cyc;
      end
      @(posedge clk); #1;
      if (tog && !seen) begin
        bus.req = ~bus.req; bus.addr = 32'hFFFF_FFF0 ^ a; bus.we = ~w; bus.wdata = ~d;
      end
      c++;
    end
    bus.req = 1'b0;
  endtask

  task automatic xact1(input logic w, input logic [31:0] a, input logic [31:0] d);
    int c;
    bit seen;
    bus1.req = 1'b1; bus1.we = w; bus1.addr = a; bus1.wdata = d;
    c = 0; seen = 0; r_busy = '0; r_lat = 99; r_err = 1'bx; r_rdata = 'x;
    while (!seen && c < 20) begin
      @(negedge clk);
      if (c < 16) r_busy[c] = bus1.busy;
      if (bus1.ack) begin
        seen = 1; r_lat = c; r_err = bus1.err; r_rdata = bus1.rdata;
      end
      @(posedge clk); #1;
      c++;
    end
    bus1.req = 1'b0;
  endtask

  initial begin
    int c1, c2, c3, acks;
    rst = 1'b1;
    bus.req = 0; bus.we = 0; bus.addr = 0; bus.wdata = 0;
    bus1.req = 0; bus1.we = 0; bus1.addr = 0; bus1.wdata = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_ack", 32'(bus.ack), 32'd0);
    chk("rst_err", 32'(bus.err), 32'd0);
    chk("rst_rdata", bus.rdata, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;

    // T1 write then read
    xact(1'b1, 32'h8, 32'hDEAD_BEEF, 0);
    chk("t1_w_lat", 32'(r_lat), 32'd4);
    chk("t1_w_busy", 32'(r_busy), 32'h000F);
    chk("t1_w_err", 32'(r_err), 32'd0);
    @(negedge clk);
    chk("t1_ack_pulse", 32'(bus.ack), 32'd0);
    @(posedge clk); #1;
    xact(1'b0, 32'h8, 32'h0, 0);
    chk("t1_r_lat", 32'(r_lat), 32'd4);
    chk("t1_r_data", r_rdata, 32'hDEAD_BEEF);
    chk("t1_r_err", 32'(r_err), 32'd0);
    @(negedge clk);
    chk("t1_rdata_hold", bus.rdata, 32'hDEAD_BEEF);
    @(posedge clk); #1;

    xact(1'b1, 32'h0, 32'h1111_2222, 0);
    xact(1'b1, 32'h4, 32'hA5A5_A5A5, 0);
    chk("w_keeps_rdata", r_rdata, 32'hDEAD_BEEF);

    // T3 misaligned
    xact(1'b1, 32'h6, 32'hFFFF_FFFF, 0);
    chk("t3_w_err", 32'(r_err), 32'd1);
    chk("t3_w_lat", 32'(r_lat), 32'd4);
    xact(1'b0, 32'h4, 32'h0, 0);
    chk("t3_mem_kept", r_rdata, 32'hA5A5_A5A5);
    chk("t3_good_err", 32'(r_err), 32'd0);
    xact(1'b0, 32'h6, 32'h0, 0);
    chk("t3_r_err", 32'(r_err), 32'd1);
    chk("t3_r_data", r_rdata, 32'h0);

    // T4 out of range
    xact(1'b1, 32'h4, 32'h0, 0);
    xact(1'b1, 32'h4, 32'hA5A5_A5A5, 0);
    xact(1'b0, 32'h80, 32'h0, 0);
    chk("t4_r_err", 32'(r_err), 32'd1);
    chk("t4_r_data", r_rdata, 32'h0);
    xact(1'b1, 32'h80, 32'hCAFE_F00D, 0);
    chk("t4_w_err", 32'(r_err), 32'd1);
    xact(1'b0, 32'h0, 32'h0, 0);
    chk("t4_no_alias", r_rdata, 32'h1111_2222);

    // T5 reset in WAIT
    bus.req = 1'b1; bus.we = 1'b1; bus.addr = 32'h4; bus.wdata = 32'h1234_5678;
    @(posedge clk); #1;
    bus.req = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    chk("t5_busy", 32'(bus.busy), 32'd0);
    chk("t5_rdata_rst", bus.rdata, 32'h0);
    acks = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (bus.ack) acks++;
      if (i == 1) begin
        @(posedge clk); #1;
        rst = 1'b0;
      end
    end
    chk("t5_no_ack", 32'(acks), 32'd0);
    @(posedge clk); #1;
    xact(1'b0, 32'h4, 32'h0, 0);
    chk("t5_r_lat", 32'(r_lat), 32'd4);
    chk("t5_word_kept", r_rdata, 32'hA5A5_A5A5);

    // T6 back-to-back with req/field toggling during WAIT/RESP
    xact(1'b1, 32'h10, 32'h0BAD_CAFE, 0);
    xact(1'b0, 32'h10, 32'h0, 1);
    c1 = r_cyc;
    chk("t6_r1", r_rdata, 32'h0BAD_CAFE);
    chk("t6_busy", 32'(r_busy), 32'h000F);
    xact(1'b0, 32'h0, 32'h0, 1);
    c2 = r_cyc;
    chk("t6_r2", r_rdata, 32'h1111_2222);
    xact(1'b0, 32'h4, 32'h0, 1);
    c3 = r_cyc;
    chk("t6_r3", r_rdata, 32'hA5A5_A5A5);
    chk("t6_gap12", 32'(c2 - c1), 32'd5);
    chk("t6_gap23", 32'(c3 - c2), 32'd5);

    // T2 LATENCY=1
    xact1(1'b1, 32'h0, 32'h0000_0077);
    chk("t2_w_lat", 32'(r_lat), 32'd1);
    xact1(1'b0, 32'h0, 32'h0);
    chk("t2_r_lat", 32'(r_lat), 32'd1);
    chk("t2_busy", 32'(r_busy), 32'h0001);
    chk("t2_r_data", r_rdata, 32'h0000_0077);
    chk("t2_r_err", 32'(r_err), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
